// File: rtl/rr_arb_4.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb_4
// Brief    : 4-requester round-robin arbiter with hold limit, driving a 4:1
//            mux select and a one-hot grant back to the requesters.
// Revision : 1.0
// ============================================================================
module rr_arb_4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] c_hold_lim = 8'(MAX_HOLD - 1);

    state_t     r_state, w_state_nxt;
    logic [1:0] r_ptr, w_ptr_nxt;
    logic [7:0] r_hold, w_hold_nxt;
    logic [1:0] r_sel, w_sel_nxt;
    logic [3:0] r_grant, w_grant_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_timeout, w_timeout_nxt;

    logic       w_at_limit;
    logic       w_release;
    logic       w_limit_only;
    logic [1:0] w_ptr_eff;
    logic [1:0] w_cand;
    logic [1:0] w_win;
    logic       w_found;

    assign w_at_limit   = (r_hold == c_hold_lim);
    assign w_release    = (r_state == GRANT) && (done || !req[r_sel] || w_at_limit);
    assign w_limit_only = (r_state == GRANT) && !done && req[r_sel] && w_at_limit;

    // A releasing holder re-arbitrates this same edge with itself as lowest priority.
    assign w_ptr_eff = w_release ? (r_sel + 2'd1) : r_ptr;

    always_comb begin
        w_found = 1'b0;
        w_win   = 2'd0;
        w_cand  = 2'd0;
        for (int k = 0; k < 4; k++) begin
            w_cand = w_ptr_eff + 2'(k);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_hold_nxt    = r_hold;
        w_sel_nxt     = r_sel;
        w_grant_nxt   = r_grant;
        w_busy_nxt    = r_busy;
        w_timeout_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = GRANT;
                    w_sel_nxt   = w_win;
                    w_grant_nxt = 4'b0001 << w_win;
                    w_busy_nxt  = 1'b1;
                    w_hold_nxt  = 8'd0;
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_ptr_nxt     = r_sel + 2'd1;
                    w_timeout_nxt = w_limit_only;
                    w_hold_nxt    = 8'd0;
                    if (w_found) begin
                        w_sel_nxt   = w_win;
                        w_grant_nxt = 4'b0001 << w_win;
                    end else begin
                        // sel keeps the last index so the mux output stays put.
                        w_state_nxt = IDLE;
                        w_grant_nxt = 4'b0000;
                        w_busy_nxt  = 1'b0;
                    end
                end else begin
                    w_hold_nxt = r_hold + 8'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = 4'b0000;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ptr     <= 2'd0;
            r_hold    <= 8'd0;
            r_sel     <= 2'd0;
            r_grant   <= 4'b0000;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_hold    <= w_hold_nxt;
            r_sel     <= w_sel_nxt;
            r_grant   <= w_grant_nxt;
            r_busy    <= w_busy_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign sel     = r_sel;
    assign grant   = r_grant;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_4.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arb_4
// Brief    : Directed self-checking bench for rr_arb_4 (MAX_HOLD = 8).
// Revision : 1.0
// ============================================================================
module tb_rr_arb_4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       busy;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    rr_arb_4 #(.MAX_HOLD(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .sel     (sel),
        .grant   (grant),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] eg, input logic [1:0] es,
                           input logic eb, input logic et);
        chk({tag, ".grant"},   32'(grant),   32'(eg));
        chk({tag, ".sel"},     32'(sel),     32'(es));
        chk({tag, ".busy"},    32'(busy),    32'(eb));
        chk({tag, ".timeout"}, 32'(timeout), 32'(et));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        #1;
        chk_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        step();
        step();
        rst_n = 1'b1;

        // Round robin with all requesters and done every grant
        req = 4'b1111;
        step();
        chk_out("rr0", 4'b0001, 2'd0, 1'b1, 1'b0);
        done = 1'b1;
        step();
        chk_out("rr1", 4'b0010, 2'd1, 1'b1, 1'b0);
        step();
        chk_out("rr2", 4'b0100, 2'd2, 1'b1, 1'b0);
        step();
        chk_out("rr3", 4'b1000, 2'd3, 1'b1, 1'b0);
        step();
        chk_out("rr4", 4'b0001, 2'd0, 1'b1, 1'b0);
        done = 1'b0;

        // Channel 0 drops, channel 2 alone: hold limit then immediate re-grant
        req = 4'b0100;
        step();
        chk_out("to_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step();
            chk_out("to_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
        end
        step();
        chk_out("to_pulse", 4'b0100, 2'd2, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step();
            chk_out("to_restart", 4'b0100, 2'd2, 1'b1, 1'b0);
        end
        step();
        chk_out("to_pulse2", 4'b0100, 2'd2, 1'b1, 1'b1);

        // done coincides with the hold limit: normal release, no timeout
        for (int i = 0; i < 7; i++) begin
            step();
            chk("lim_hold.grant", 32'(grant), 32'(4'b0100));
        end
        done = 1'b1;
        step();
        chk_out("lim_done", 4'b0100, 2'd2, 1'b1, 1'b0);
        done = 1'b0;

        // Go idle, sel keeps 2
        req = 4'b0000;
        step();
        chk_out("idle_a", 4'b0000, 2'd2, 1'b0, 1'b0);

        // Channel 1 holds, other requests do not disturb it, then drops
        req = 4'b0010;
        step();
        chk_out("ch1", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b1010;
        step();
        chk_out("ch1_keep", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b1000;
        step();
        chk_out("ch1_drop", 4'b1000, 2'd3, 1'b1, 1'b0);

        // Channel 3 releases with no requesters; done in idle is ignored
        req  = 4'b0000;
        step();
        chk_out("idle_b", 4'b0000, 2'd3, 1'b0, 1'b0);
        done = 1'b1;
        step();
        chk_out("idle_done", 4'b0000, 2'd3, 1'b0, 1'b0);
        done = 1'b0;
        req  = 4'b0001;
        step();
        chk_out("idle_req", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Channel 1 granted, then asynchronous reset mid-grant
        req = 4'b0010;
        step();
        chk_out("pre_rst", 4'b0010, 2'd1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b0110;
        step();
        chk_out("in_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        chk_out("post_rst", 4'b0010, 2'd1, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
